// File: rtl/qdec_ctu_bank_buffer.sv
// ============================================================================
//  Module   : qdec_ctu_bank_buffer
//  Purpose  : N-bank rotating CTU syntax buffer for the CABAC decoder. The
//             parser fills one bank per CTU and commits it. Consumers read
//             committed banks oldest-first and release them. The parser may
//             run up to NUM_BANKS-1 CTUs ahead of the consumer.
//  Options  : `define QDEC_CTU_BANK_CLR_EN to enable the hardware bank-clear
//             engine. When enabled, every released bank is zeroed, one word
//             per cycle. Without it, released banks keep stale data.
//  Ports    : clk, rst_n (synchronous, active-low)
//             wr_en/wr_addr/wr_data  - write into the current write bank
//             wr_commit              - hand the current write bank to readers
//             wr_ready               - a writable bank is available
//             rd_en/rd_addr          - read from the oldest committed bank
//             rd_data/rd_valid       - read result, one cycle after rd_en
//             rd_release             - oldest committed bank is consumed
//             rd_avail/occupancy     - committed-bank status
//             clr_busy               - clear engine active
//             wr_err/rd_err          - one-cycle pulse, strobe was dropped
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Single-bank storage: one write port and one registered read port. The
// read register resets to zero so that the buffer output is 0 after reset.
module basic_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

module qdec_ctu_bank_buffer #(
  parameter int NUM_BANKS = 2,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int OCC_W     = $clog2(NUM_BANKS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_commit,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_release,
  output logic              rd_avail,
  output logic [OCC_W-1:0]  occupancy,
  output logic              clr_busy,
  output logic              wr_err,
  output logic              rd_err
);

  localparam int               PTR_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [OCC_W-1:0] FULL_CNT  = OCC_W'(NUM_BANKS);
  localparam logic [PTR_W-1:0] LAST_BANK = PTR_W'(NUM_BANKS - 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;
  logic [PTR_W-1:0] rd_bank_q;   // bank that produced the current rd_data

  logic             wr_acc;
  logic             commit_acc;
  logic             rd_acc;
  logic             release_acc;

  logic [PTR_W-1:0]  clr_bank;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_we;

  logic [DATA_W-1:0] bank_q [NUM_BANKS];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_BANK) ? '0 : p + 1'b1;
  endfunction

  // A bank still being zeroed must not be refilled, even if a slot is free.
  assign wr_ready    = (count < FULL_CNT) && !(clr_busy && (clr_bank == wr_ptr));
  assign rd_avail    = (count != '0);
  assign occupancy   = count;

  assign wr_acc      = wr_en     && wr_ready;
  assign commit_acc  = wr_commit && wr_ready;
  assign rd_acc      = rd_en     && rd_avail;
  // Only one clear can be in flight, so a release during a clear is refused.
  assign release_acc = rd_release && rd_avail && !clr_busy;

  // --------------------------------------------------------------------------
  // Pointers, occupancy, error pulses and read-valid
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_bank_q <= '0;
      rd_valid  <= 1'b0;
      wr_err    <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      if (commit_acc) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (release_acc) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({commit_acc, release_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A read in the same cycle as a release still targets the old bank.
      if (rd_acc) begin
        rd_bank_q <= rd_ptr;
      end
      rd_valid <= rd_acc;
      wr_err   <= (wr_en || wr_commit) && !wr_ready;
      rd_err   <= (rd_en && !rd_avail) || (rd_release && !release_acc);
    end
  end

  // --------------------------------------------------------------------------
  // Bank clear engine
  // --------------------------------------------------------------------------
`ifdef QDEC_CTU_BANK_CLR_EN
  typedef enum logic [0:0] {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

  clr_state_t clr_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_state <= CLR_IDLE;
      clr_bank  <= '0;
      clr_addr  <= '0;
    end else begin
      case (clr_state)
        CLR_IDLE: begin
          if (release_acc) begin
            clr_state <= CLR_RUN;
            clr_bank  <= rd_ptr;
            clr_addr  <= '0;
          end
        end
        CLR_RUN: begin
          // One word per cycle; the last address ends the clear.
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == {ADDR_W{1'b1}}) begin
            clr_state <= CLR_IDLE;
          end
        end
        default: clr_state <= CLR_IDLE;
      endcase
    end
  end

  assign clr_busy = (clr_state == CLR_RUN);
  assign clr_we   = clr_busy;
`else
  assign clr_busy = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_bank = '0;
  assign clr_addr = '0;
`endif

  // --------------------------------------------------------------------------
  // Bank storage. The clear engine and the parser never target the same bank
  // because wr_ready is low whenever wr_ptr points at the bank under clear.
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic              is_wr_bank;
    logic              is_clr_bank;
    logic              bank_we;
    logic [ADDR_W-1:0] bank_waddr;
    logic [DATA_W-1:0] bank_wdata;
    logic              bank_re;

    assign is_wr_bank  = (wr_ptr == PTR_W'(b));
    assign is_clr_bank = clr_we && (clr_bank == PTR_W'(b));
    assign bank_we     = (wr_acc && is_wr_bank) || is_clr_bank;
    assign bank_waddr  = is_clr_bank ? clr_addr : wr_addr;
    assign bank_wdata  = is_clr_bank ? '0 : wr_data;
    assign bank_re     = rd_acc && (rd_ptr == PTR_W'(b));

    basic_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bank_we),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .re    (bank_re),
      .raddr (rd_addr),
      .rdata (bank_q[b])
    );
  end

  // Each bank's read register holds its last value, and the registered
  // bank index only moves on an accepted read, so rd_data holds in between.
  assign rd_data = bank_q[rd_bank_q];

endmodule

`default_nettype wire

// File: tb/tb_qdec_ctu_bank_buffer.sv
`default_nettype none

module tb_qdec_ctu_bank_buffer;

  localparam int NB = 4;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int OW = 3;
  localparam int DEPTH = 1 << AW;
`ifdef QDEC_CTU_BANK_CLR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_commit = 1'b0;
  logic          wr_ready;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_release = 1'b0;
  logic          rd_avail;
  logic [OW-1:0] occupancy;
  logic          clr_busy;
  logic          wr_err;
  logic          rd_err;

  qdec_ctu_bank_buffer #(
    .NUM_BANKS (NB),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_commit  (wr_commit),
    .wr_ready   (wr_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_release (rd_release),
    .rd_avail   (rd_avail),
    .occupancy  (occupancy),
    .clr_busy   (clr_busy),
    .wr_err     (wr_err),
    .rd_err     (rd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: banks as plain arrays, a FIFO of committed banks
  // described by head/tail indices and a count, and a clear countdown.
  // --------------------------------------------------------------------------
  logic [DW-1:0] mem   [NB][DEPTH];
  bit            known [NB][DEPTH];
  int            m_count, m_wp, m_rp, m_clr_cnt, m_clr_bank;
  bit            m_rd_valid, m_rd_known, m_wr_err, m_rd_err;
  logic [DW-1:0] m_rd_data;

  function automatic bit m_ready();
    return (m_count < NB) && !(m_clr_cnt > 0 && m_clr_bank == m_wp);
  endfunction

  task automatic model_edge(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                            input bit wc, input bit re, input logic [AW-1:0] ra,
                            input bit rr, input bit rst);
    bit rdy, av, relok;
    if (rst) begin
      m_count = 0; m_wp = 0; m_rp = 0; m_clr_cnt = 0; m_clr_bank = 0;
      m_rd_valid = 0; m_rd_data = '0; m_rd_known = 1;
      m_wr_err = 0; m_rd_err = 0;
      for (int b = 0; b < NB; b++)
        for (int a = 0; a < DEPTH; a++) known[b][a] = 0;
      return;
    end
    rdy   = m_ready();
    av    = (m_count != 0);
    relok = rr && av && !(m_clr_cnt > 0);
    m_wr_err = (we || wc) && !rdy;
    m_rd_err = (re && !av) || (rr && !relok);
    if (re && av) begin
      m_rd_valid = 1;
      m_rd_data  = mem[m_rp][ra];
      m_rd_known = known[m_rp][ra];
    end else begin
      m_rd_valid = 0;
    end
    if (we && rdy) begin
      mem[m_wp][wa]   = wd;
      known[m_wp][wa] = 1;
    end
    if (m_clr_cnt > 0) m_clr_cnt--;
    if (relok && CLR_EN) begin
      // The cleared bank is unreachable until the clear ends, so it can be
      // treated as zero straight away.
      m_clr_cnt  = DEPTH;
      m_clr_bank = m_rp;
      for (int a = 0; a < DEPTH; a++) begin
        mem[m_rp][a]   = '0;
        known[m_rp][a] = 1;
      end
    end
    if (wc && rdy) m_wp = (m_wp + 1) % NB;
    if (relok)     m_rp = (m_rp + 1) % NB;
    m_count = m_count + int'(wc && rdy) - int'(relok);
  endtask

  task automatic check_model();
    chk("wr_ready",  wr_ready,  m_ready());
    chk("rd_avail",  rd_avail,  m_count != 0);
    chk("occupancy", occupancy, m_count);
    chk("clr_busy",  clr_busy,  m_clr_cnt > 0);
    chk("rd_valid",  rd_valid,  m_rd_valid);
    chk("wr_err",    wr_err,    m_wr_err);
    chk("rd_err",    rd_err,    m_rd_err);
    if (m_rd_known) chk("rd_data", rd_data, m_rd_data);
  endtask

  task automatic step(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit wc, input bit re, input logic [AW-1:0] ra,
                      input bit rr, input bit rst);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_commit = wc;
    rd_en = re; rd_addr = ra; rd_release = rr; rst_n = !rst;
    @(posedge clk);
    model_edge(we, wa, wd, wc, re, ra, rr, rst);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, '0, 0, 0);
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    bit            we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    bit            wc;
    bit            re;
    logic [AW-1:0] ra;
    bit            rr;
    bit            e_ready;
    bit            e_avail;
    int            e_occ;
    bit            e_valid;
    logic [DW-1:0] e_data;
    bit            e_werr;
    bit            e_rerr;
  } vec_t;

  function automatic vec_t mk(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input bit wc, input bit re, input logic [AW-1:0] ra, input bit rr,
                              input bit e_ready, input bit e_avail, input int e_occ,
                              input bit e_valid, input logic [DW-1:0] e_data,
                              input bit e_werr, input bit e_rerr);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.wc = wc; v.re = re; v.ra = ra; v.rr = rr;
    v.e_ready = e_ready; v.e_avail = e_avail; v.e_occ = e_occ; v.e_valid = e_valid;
    v.e_data = e_data; v.e_werr = e_werr; v.e_rerr = e_rerr;
    return v;
  endfunction

  vec_t tbl [11];

  initial begin
    int n;
    //                we wa  wd     wc re ra  rr | rdy    av occ vld data   we re
    tbl[0]  = mk(0, 0, 8'h00, 0, 0, 0, 1,   1,       0, 0,  0, 8'h00, 0, 1);
    tbl[1]  = mk(0, 0, 8'h00, 0, 1, 0, 0,   1,       0, 0,  0, 8'h00, 0, 1);
    tbl[2]  = mk(1, 3, 8'hA5, 0, 0, 0, 0,   1,       0, 0,  0, 8'h00, 0, 0);
    tbl[3]  = mk(0, 0, 8'h00, 1, 0, 0, 0,   1,       1, 1,  0, 8'h00, 0, 0);
    tbl[4]  = mk(0, 0, 8'h00, 0, 1, 3, 0,   1,       1, 1,  1, 8'hA5, 0, 0);
    tbl[5]  = mk(1, 3, 8'h5A, 1, 0, 0, 0,   1,       1, 2,  0, 8'hA5, 0, 0);
    tbl[6]  = mk(1, 3, 8'hC3, 1, 0, 0, 0,   1,       1, 3,  0, 8'hA5, 0, 0);
    tbl[7]  = mk(1, 3, 8'h3C, 1, 0, 0, 0,   0,       1, 4,  0, 8'hA5, 0, 0);
    tbl[8]  = mk(1, 3, 8'hEE, 1, 0, 0, 0,   0,       1, 4,  0, 8'hA5, 1, 0);
    tbl[9]  = mk(0, 0, 8'h00, 0, 1, 3, 1,   !CLR_EN, 1, 3,  1, 8'hA5, 0, 0);
    tbl[10] = mk(0, 0, 8'h00, 0, 0, 0, 0,   !CLR_EN, 1, 3,  0, 8'hA5, 0, 0);

    // Reset state
    step(0, '0, '0, 0, 0, '0, 0, 1);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_data",  rd_data,  0);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].wc, tbl[i].re, tbl[i].ra, tbl[i].rr, 0);
      chk($sformatf("tbl%0d_wr_ready", i),  wr_ready,  tbl[i].e_ready);
      chk($sformatf("tbl%0d_rd_avail", i),  rd_avail,  tbl[i].e_avail);
      chk($sformatf("tbl%0d_occupancy", i), occupancy, tbl[i].e_occ);
      chk($sformatf("tbl%0d_rd_valid", i),  rd_valid,  tbl[i].e_valid);
      chk($sformatf("tbl%0d_rd_data", i),   rd_data,   tbl[i].e_data);
      chk($sformatf("tbl%0d_wr_err", i),    wr_err,    tbl[i].e_werr);
      chk($sformatf("tbl%0d_rd_err", i),    rd_err,    tbl[i].e_rerr);
    end

    // Commit and release together at occupancy 2, then read across 3 -> 0.
    idle(DEPTH + 2);
    step(0, '0, '0, 0, 0, '0, 1, 0);              // release bank1
    idle(DEPTH + 2);
    chk("pre_both_occ", occupancy, 2);
    step(1, 4'd3, 8'h77, 1, 0, '0, 1, 0);        // fill+commit bank0, release bank2
    chk("both_occ", occupancy, 2);
    idle(DEPTH + 2);
    step(0, '0, '0, 0, 1, 4'd3, 0, 0);           // oldest is bank3
    chk("wrap_rd3_valid", rd_valid, 1);
    chk("wrap_rd3_data",  rd_data,  8'h3C);
    step(0, '0, '0, 0, 0, '0, 1, 0);              // rd_ptr 3 -> 0
    idle(DEPTH + 2);
    step(0, '0, '0, 0, 1, 4'd3, 0, 0);
    chk("wrap_rd0_data", rd_data, 8'h77);

    // Reset mid-stream with three committed banks.
    step(0, '0, '0, 0, 0, '0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, '0, '0, 1, 0, '0, 0, 0);
    chk("mid_occ3", occupancy, 3);
    step(0, '0, '0, 1, 1, '0, 1, 1);
    chk("mid_rst_wr_ready", wr_ready,  1);
    chk("mid_rst_rd_avail", rd_avail,  0);
    chk("mid_rst_occ",      occupancy, 0);
    chk("mid_rst_rd_valid", rd_valid,  0);
    chk("mid_rst_rd_data",  rd_data,   0);
    chk("mid_rst_clr_busy", clr_busy,  0);
    chk("mid_rst_wr_err",   wr_err,    0);
    chk("mid_rst_rd_err",   rd_err,    0);

`ifdef QDEC_CTU_BANK_CLR_EN
    // Clear engine: fill bank0 with 0xFF, release it, time the clear.
    for (int a = 0; a < DEPTH; a++) step(1, AW'(a), 8'hFF, 0, 0, '0, 0, 0);
    step(0, '0, '0, 1, 0, '0, 0, 0);              // commit bank0
    step(0, '0, '0, 1, 0, '0, 0, 0);              // commit bank1
    step(0, '0, '0, 0, 0, '0, 1, 0);              // release bank0 -> clear
    n = clr_busy ? 1 : 0;
    for (int k = 0; k < 40 && clr_busy; k++) begin
      step(0, '0, '0, 0, 0, '0, (k == 0), 0);
      if (k == 0) begin
        chk("clr_rel_rd_err", rd_err,    1);
        chk("clr_rel_occ",    occupancy, 1);
      end
      if (clr_busy) n++;
    end
    chk("clr_busy_cycles", n, DEPTH);
    for (int i = 0; i < 3; i++) step(0, '0, '0, 1, 0, '0, 0, 0);  // banks 2,3,0
    chk("clr_occ4", occupancy, 4);
    for (int i = 0; i < 3; i++) begin
      step(0, '0, '0, 0, 0, '0, 1, 0);
      idle(DEPTH + 2);
    end
    for (int a = 0; a < DEPTH; a++) begin
      step(0, '0, '0, 0, 1, AW'(a), 0, 0);
      chk($sformatf("clr_rd%0d", a), rd_data, 0);
    end
`else
    n = 0;
`endif

    // Randomized traffic against the model.
    step(0, '0, '0, 0, 0, '0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99, 0) < 50, AW'($urandom), DW'($urandom),
           $urandom_range(99, 0) < 15, $urandom_range(99, 0) < 50, AW'($urandom),
           $urandom_range(99, 0) < 12, $urandom_range(999, 0) < 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/qdec_ctu_bank_buffer.md
# qdec_ctu_bank_buffer

Parametrised N-bank rotating CTU syntax buffer for the CABAC decoder: the generalisation of the two-bank ping-pong CTU line buffer. The parser fills one bank per CTU and commits it. Downstream consumers read committed banks in commit order and release them. Full/empty flow control, error flags and an optional hardware bank-clear engine are added, so the parser can run up to NUM_BANKS-1 CTUs ahead without corrupting unread data.

## Interface
- NUM_BANKS, 2, number of CTU banks (≥2)
- ADDR_W, 12, byte address width per bank (bank depth 2^ADDR_W)
- DATA_W, 8, data word width
- OCC_W, $clog2(NUM_BANKS+1), occupancy width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  write strobe into current write bank
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_commit  in  1  pulse: current write bank complete, hand to read side
- wr_ready  out  1  a writable bank is available
- rd_en  in  1  read strobe from oldest committed bank
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data valid
- rd_release  in  1  pulse: oldest committed bank consumed
- rd_avail  out  1  at least one committed bank
- occupancy  out  OCC_W  number of committed, unreleased banks
- clr_busy  out  1  clear engine active (tied 0 without macro)
- wr_err  out  1  one-cycle pulse: write/commit dropped
- rd_err  out  1  one-cycle pulse: read/release dropped

## Operation
- State: wr_ptr, rd_ptr (mod NUM_BANKS) and count (0..NUM_BANKS). count drives occupancy.
- wr_ready = (count < NUM_BANKS) && !(clr_busy && clr_bank == wr_ptr). rd_avail = (count != 0).
- Writes go to bank wr_ptr only when wr_ready. wr_en with !wr_ready: write dropped, wr_err pulses.
- Accepted wr_commit (wr_ready=1): wr_ptr+1 wrapping at NUM_BANKS-1→0, count+1. A wr_en in the same cycle as wr_commit lands in the old bank. wr_commit with !wr_ready: ignored, wr_err.
- Reads address bank rd_ptr. rd_en with !rd_avail: no access, rd_valid stays 0, rd_err pulses.
- Accepted rd_release (rd_avail=1): rd_ptr+1 wrapping, count−1. rd_release with count==0: ignored, rd_err.
- Simultaneous accepted commit and release: both pointers advance, count unchanged.
- Since count>0 whenever reads are legal, rd_ptr≠wr_ptr unless count==NUM_BANKS, and writes are blocked in that case. Read and write therefore never hit the same bank.
- rd_en and rd_release in the same cycle: the read uses the pre-release rd_ptr.
- Each bank is a basic_ram instance (1 write port, 1 registered read port). The output mux uses a registered bank index.

## Timing
- Read latency 1: rd_en accepted in cycle N → rd_data/rd_valid in N+1. rd_data holds its value when rd_valid=0.
- wr_ready, rd_avail and occupancy reflect the new count one cycle after commit or release.
- wr_err and rd_err are registered and assert the cycle after the offending strobe.
- Reset values:
  - wr_ptr=rd_ptr=count=0, rd_valid=0, rd_data=0, wr_ready=1, rd_avail=0, occupancy=0, clr_busy=0, wr_err=rd_err=0.
  - Memory contents are undefined.
- Reset asserted mid-operation discards all banks and aborts any clear.

## Configuration
- QDEC_CTU_BANK_CLR_EN defined:
  - An accepted rd_release starts a clear of the released bank (clr_bank=old rd_ptr). The engine writes 0 to addresses 0..2^ADDR_W−1, one per cycle.
  - clr_busy is high for exactly 2^ADDR_W cycles starting the cycle after release.
  - rd_release while clr_busy: ignored, rd_err pulses, count unchanged.
  - A bank under clear is not writable (see wr_ready).
- Macro undefined: no clear engine, clr_busy=0 constant, released banks keep stale data.

## Test plan
- NUM_BANKS=2, ADDR_W=4: write 0xA5 @3, commit, rd_en @3 → rd_data=0xA5, rd_valid one cycle later; occupancy=1.
- NUM_BANKS=4: commit 4 banks without release → wr_ready=0 after 4th; 5th commit → wr_err pulse, occupancy stays 4.
- Release with occupancy=0 → rd_err pulse, rd_ptr unchanged; rd_en with rd_avail=0 → rd_valid=0, rd_err.
- Occupancy=2, commit and release in same cycle → occupancy stays 2, banks read in commit order across wrap 3→0.
- Reset mid-stream with occupancy=3 → all outputs return to reset values next cycle, wr_ready=1.
- CLR_EN, ADDR_W=4: release bank holding 0xFF → clr_busy high 16 cycles; second release during clear → rd_err; recommit without writes → reads return 0.
